rv32_imm_encoder: RTL and testbench
===================================

Name: rv32_imm_encoder

Overview:
- Inverse of the decode-side immediate selection. Accepts instruction fields (opcode, registers, funct3, 12-bit immediate) over a valid/ready handshake.
- Packs the immediate into the I-type or S-type bit positions, builds the full 32-bit RV32 word and writes it to instruction memory at sequential addresses.
- Used by the test/boot loader path to fill IMEM with LOAD, STORE and OP-IMM programs before the pipeline is released.

Parameters:
- ADDR_W, 6: IMEM word-address width. Capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: clear pointer and error, enter RUN
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_opcode  in  7  RV32 major opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (S-type only)
- in_funct3  in  3  funct3
- in_imm  in  12  immediate, two's complement
- wr_en  out  1  IMEM write strobe
- wr_addr  out  ADDR_W  IMEM word address
- wr_data  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- full  out  1  DEPTH words written
- err  out  1  sticky: an unsupported opcode was received

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0.
- FSM states: IDLE, RUN, FULL.
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready = ~start.
  - FULL: in_ready=0, full=1. start -> RUN.
  - start in any state (including RUN mid-stream): next cycle pointer=0, count=0, err=0, state=RUN. A bundle presented in the same cycle as start is not accepted.
- Accept: in_valid & in_ready. Fields are registered; the write appears in the following cycle.
  - wr_en=1 for exactly 1 cycle.
  - wr_addr = pointer at acceptance.
  - Pointer and count increment on that same cycle.
  - Latency is 1 cycle, and back-to-back accepts are permitted every cycle.
- Encoding:
  - LOAD 0000011, OP_IMM 0010011 (I-type): wr_data = {imm[11:0], rs1, funct3, rd, opcode}.
  - STORE 0100011 (S-type): wr_data = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. rd is ignored.
  - Any other opcode: the handshake completes and the bundle is consumed, but wr_en stays 0. err is set sticky, and pointer and count are unchanged.
- wr_data and wr_addr hold their last values when wr_en=0.
- Full boundary: an accept that makes count == DEPTH moves RUN -> FULL. in_ready drops in the next cycle, the same cycle that last write is presented. The pointer wraps to 0 but no write occurs until start. There is no overflow write.
- An illegal opcode on the final slot does not advance the FSM to FULL.
- rst mid-stream: a pending write is dropped (wr_en=0 next cycle) and all state returns to reset values.

Optional Feature:
- Macro: RV32_IMM_ENC_BRANCH_EN.
- When defined: opcode BRANCH 1100011 is a supported B-type encoding. in_imm holds offset[12:1]. wr_data = {in_imm[11], in_imm[9:4], rs2, rs1, funct3, in_imm[3:0], in_imm[10], opcode}.
- When undefined: BRANCH is treated as unsupported. err is set and no write occurs.

Test Plan:
- Reset, start, then ADDI x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=0x005) -> next cycle wr_en=1, wr_addr=0, wr_data=0x00500093, count=1.
- Back-to-back with in_valid held: LW x2,8(x1) (f3=010) then SW x2,12(x1) (f3=010) -> wr_data 0x0080A103 @addr 0, then 0x0020A623 @addr 1, in consecutive cycles.
- Negative immediate: ADDI x1,x1,-1 (imm=0xFFF) -> wr_data=0xFFF08093. Bundle with opcode 0110011 -> accepted, no wr_en, err=1, count unchanged; the next start clears err.
- ADDR_W=2: 4 valid accepts -> writes at addr 0..3, full=1, in_ready=0, a 5th in_valid is held off. start -> count=0, in_ready=1, the next write goes to addr 0.
- start asserted together with in_valid mid-stream -> that bundle is not accepted. rst asserted the cycle after an accept -> no wr_en, all outputs at reset values.
- With RV32_IMM_ENC_BRANCH_EN: BEQ x1,x2,+8 (in_imm=0x004, rs1=1, rs2=2, f3=0) -> wr_data=0x00208463. Without the macro -> err=1, no write.

Source files
------------

// File: rtl/rv32_imm_encoder.sv
// rtl/rv32_imm_encoder.sv - RV32 I/S-type instruction encoder that fills IMEM at sequential addresses
//
// Optional build macro: RV32_IMM_ENC_BRANCH_EN (adds B-type BRANCH encoding).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse: clear pointer/count/err and enter RUN
//   in_valid/in_ready   field bundle handshake
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm   instruction fields
//   wr_en/wr_addr/wr_data   one-cycle IMEM write strobe, word address, encoded word
//   count               words written since start
//   full                DEPTH words written; held until start
//   err                 sticky: unsupported opcode received
module rv32_imm_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [11:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
`ifdef RV32_IMM_ENC_BRANCH_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`endif

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              legal;
    logic              last_slot;
    logic [31:0]       enc;

    // Field packing; legal is low for any opcode this build does not encode.
    always_comb begin
        legal = 1'b0;
        enc   = '0;
        case (in_opcode)
            OP_LOAD, OP_IMM: begin
                legal = 1'b1;
                enc   = {in_imm, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_STORE: begin
                legal = 1'b1;
                enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
`ifdef RV32_IMM_ENC_BRANCH_EN
            // in_imm carries offset[12:1]; scatter into the B-type slots.
            OP_BRANCH: begin
                legal = 1'b1;
                enc   = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                         in_imm[3:0], in_imm[10], in_opcode};
            end
`endif
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign last_slot = (count == (DEPTH_CNT - CNT_ONE));
    assign full      = (state == S_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                // A bundle offered alongside start is refused so it cannot
                // land in the stream that start is about to restart.
                in_ready = ~start;
                if (start) begin
                    state_next = S_RUN;
                end else if (accept && legal && last_slot) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (start) state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
            err     <= 1'b0;
            ptr     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                ptr   <= '0;
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr;
                    wr_data <= enc;
                    ptr     <= ptr + PTR_ONE;   // wraps to 0 on the last slot
                    count   <= count + CNT_ONE;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_imm_encoder.sv
// tb/tb_rv32_imm_encoder.sv - self-checking bench for rv32_imm_encoder against a field-arithmetic model
module tb_rv32_imm_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [11:0]   in_imm = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model
    bit          m_run = 0;
    bit          m_full = 0;
    bit          m_err = 0;
    bit          m_wen = 0;
    int          m_ptr = 0;
    int          m_cnt = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;

    rv32_imm_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit m_legal(input logic [6:0] op);
        if (op == 7'h03 || op == 7'h13 || op == 7'h23) return 1'b1;
`ifdef RV32_IMM_ENC_BRANCH_EN
        if (op == 7'h63) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Encoding built with shifts and masks on integer field values.
    function automatic logic [31:0] m_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input int f3, input int imm);
        int off;
        int base;
        base = (rs1 << 15) + (f3 << 12) + op;
        if (op == 'h23)
            return 32'(((imm >> 5) << 25) + (rs2 << 20) + base + ((imm % 32) << 7));
        if (op == 'h63) begin
            off = imm * 2;
            return 32'((((off >> 12) & 1) << 31) + (((off >> 5) & 63) << 25) + (rs2 << 20) + base
                       + (((off >> 1) & 15) << 8) + (((off >> 11) & 1) << 7));
        end
        return 32'((imm << 20) + base + (rd << 7));
    endfunction

    // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic cyc(input bit r, input bit s, input bit v, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [11:0] imm);
        bit acc;
        rst = r; start = s; in_valid = v; in_opcode = op; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_run & ~s));
        acc = v & m_run & ~s;
        m_wen = 0;
        if (r) begin
            m_run = 0; m_full = 0; m_err = 0; m_ptr = 0; m_cnt = 0; m_addr = 0; m_data = '0;
        end else if (s) begin
            m_run = 1; m_full = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
        end else if (acc) begin
            if (m_legal(op)) begin
                m_wen  = 1;
                m_addr = m_ptr;
                m_data = m_enc(int'(op), int'(rd), int'(rs1), int'(rs2), int'(f3), int'(imm));
                m_ptr  = (m_ptr + 1) % DEPTH;
                m_cnt  = m_cnt + 1;
                if (m_cnt == DEPTH) begin
                    m_run = 0; m_full = 1;
                end
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("wr_en",   32'(wr_en),   32'(m_wen));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", wr_data,      m_data);
        chk("count",   32'(count),   32'(m_cnt));
        chk("full",    32'(full),    32'(m_full));
        chk("err",     32'(err),     32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 7'h13, 0, 0, 0, 0, 0);
    endtask

    task automatic go();
        cyc(0, 1, 0, 7'h13, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset values and IDLE refusing bundles
        cyc(1, 0, 0, 7'h13, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 7'h13, 1, 0, 0, 0, 12'h005);
        chk("idle_no_write", 32'(wr_en), 32'h0);

        // ADDI x1,x0,5
        go();
        cyc(0, 0, 1, 7'h13, 1, 0, 0, 3'b000, 12'h005);
        chk("addi_word", wr_data, 32'h00500093);

        // LW x2,8(x1) then SW x2,12(x1) back to back
        go();
        cyc(0, 0, 1, 7'h03, 2, 1, 0, 3'b010, 12'h008);
        chk("lw_word", wr_data, 32'h0080A103);
        cyc(0, 0, 1, 7'h23, 0, 1, 2, 3'b010, 12'h00C);
        chk("sw_word", wr_data, 32'h0020A623);
        chk("sw_addr", 32'(wr_addr), 32'd1);

        // Negative immediate, unsupported opcode, start clears err
        cyc(0, 0, 1, 7'h13, 1, 1, 0, 3'b000, 12'hFFF);
        chk("addi_neg_word", wr_data, 32'hFFF08093);
        cyc(0, 0, 1, 7'h33, 3, 1, 2, 3'b000, 12'h000);
        chk("illegal_err", 32'(err), 32'h1);
        go();

        // Fill all slots, 5th bundle held off, start restarts at addr 0
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 7'h13, 5'(i), 0, 0, 0, 12'(i));
        chk("full_flag", 32'(full), 32'h1);
        cyc(0, 0, 1, 7'h13, 7, 0, 0, 0, 12'h7);
        cyc(0, 0, 1, 7'h13, 7, 0, 0, 0, 12'h7);
        go();
        cyc(0, 0, 1, 7'h03, 4, 2, 0, 3'b010, 12'h010);
        chk("restart_addr", 32'(wr_addr), 32'h0);

        // Illegal opcode on the last slot keeps RUN
        go();
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 1, 7'h13, 1, 0, 0, 0, 12'h1);
        cyc(0, 0, 1, 7'h7F, 1, 0, 0, 0, 12'h1);
        cyc(0, 0, 1, 7'h13, 1, 0, 0, 0, 12'h2);

        // start with in_valid mid-stream, then accept followed by rst
        go();
        cyc(0, 0, 1, 7'h13, 1, 0, 0, 0, 12'h1);
        cyc(0, 1, 1, 7'h13, 2, 0, 0, 0, 12'h2);
        cyc(0, 0, 1, 7'h13, 3, 0, 0, 0, 12'h3);
        cyc(1, 0, 0, 7'h13, 0, 0, 0, 0, 0);

        // BEQ x1,x2,+8
        go();
        cyc(0, 0, 1, 7'h63, 0, 1, 2, 3'b000, 12'h004);
`ifdef RV32_IMM_ENC_BRANCH_EN
        chk("beq_word", wr_data, 32'h00208463);
`else
        chk("beq_err", 32'(err), 32'h1);
`endif

        // Randomized traffic
        go();
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            int pick;
            pick = $urandom_range(0, 5);
            case (pick)
                0: op = 7'h03;
                1: op = 7'h13;
                2: op = 7'h23;
                3: op = 7'h63;
                4: op = 7'($urandom);
                default: op = 7'h13;
            endcase
            cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 12) == 0),
                ($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 12'($urandom));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
